prog_loader: RTL and testbench

Program loader for the multicycle CPU. It receives a framed byte stream, assembles big-endian 32-bit instruction words and writes them into instruction memory. It holds the CPU in reset (`CpuRST`) until a complete frame passes its checksum. It is the write side of the instruction memory that the CPU's fetch (IF) state reads, and it sits between the host byte link and the instruction-memory write port.

---
 rtl/prog_loader.sv | 147 ++++++++++++++
 tb/tb_prog_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte stream (16-bit word count, big-endian
// payload words, XOR checksum), writes each assembled word to instruction
// memory, and holds the CPU in reset until a frame is accepted.
module prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic [7:0]        InByte,
    input  logic              InValid,
    output logic              InReady,
    output logic              MemWre,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemData,
    output logic              CpuRST,
    output logic              Busy,
    output logic              Done,
    output logic              LoadErr
);

    // Largest word count that fits in instruction memory.
    localparam logic [16:0] MAX_WORDS = 17'(1 << (ADDR_W - 2));

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [7:0]        len_hi;
    logic [15:0]       remaining;
    logic [23:0]       word_sr;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        csum;

    logic        xfer;
    logic        start_go;
    logic [15:0] len_n;

    assign xfer     = InValid & InReady;
    assign len_n    = {len_hi, InByte};
    assign start_go = Start && (state == S_IDLE || state == S_DONE || state == S_ERROR);

    // Status outputs decoded from the state register only, so InReady has
    // no combinational path from InValid.
    assign InReady = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                     (state == S_DATA)   || (state == S_CSUM);
    assign Busy    = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA) ||
                     (state == S_WRITE)  || (state == S_CSUM);
    assign Done    = (state == S_DONE);
    assign LoadErr = (state == S_ERROR);
    assign CpuRST  = (state != S_DONE);

    // Next-state logic for the frame parser.
    always_comb begin
        // NOTE: state_n gets its default first so no path through the case
        // leaves it unassigned, which would otherwise infer a latch.
        state_n = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (Start) state_n = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (xfer) state_n = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if ({1'b0, len_n} > MAX_WORDS) state_n = S_ERROR;
                    else if (len_n == 16'd0)       state_n = S_CSUM;
                    else                           state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer && byte_cnt == 2'd3) state_n = S_WRITE;
            end
            S_WRITE: begin
                state_n = (remaining == 16'd1) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (xfer) state_n = (InByte == csum) ? S_DONE : S_ERROR;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (RST) state <= S_IDLE;
        else     state <= state_n;
    end

    // Datapath: length capture, word assembly, checksum and the registered
    // memory write port.
    always_ff @(posedge CLK) begin
        if (RST) begin
            len_hi    <= '0;
            remaining <= '0;
            word_sr   <= '0;
            byte_cnt  <= '0;
            addr      <= '0;
            csum      <= '0;
            MemWre    <= 1'b0;
            MemAddr   <= '0;
            MemData   <= '0;
        end else begin
            MemWre <= 1'b0;
            if (start_go) begin
                addr     <= '0;
                csum     <= '0;
                byte_cnt <= '0;
            end
            case (state)
                S_LEN_HI: if (xfer) len_hi <= InByte;
                S_LEN_LO: if (xfer) remaining <= len_n;
                S_DATA: begin
                    if (xfer) begin
                        word_sr  <= {word_sr[15:0], InByte};
                        csum     <= csum ^ InByte;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            MemWre  <= 1'b1;
                            MemAddr <= addr;
                            MemData <= {word_sr, InByte};
                        end
                    end
                end
                S_WRITE: begin
                    addr      <= addr + ADDR_W'(4);
                    remaining <= remaining - 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: good, bad-checksum, empty, oversize,
// gapped and reset-interrupted frames with hand-computed expectations.
module tb_prog_loader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Start = 1'b0;
    logic [7:0]  InByte = 8'h00;
    logic        InValid = 1'b0;
    logic        InReady;
    logic        MemWre;
    logic [7:0]  MemAddr;
    logic [31:0] MemData;
    logic        CpuRST;
    logic        Busy;
    logic        Done;
    logic        LoadErr;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    // Good 2-word frame; payload XOR = 0x22^0x18^0xFC = 0xC6.
    logic [7:0] good [11] = '{8'h00, 8'h02, 8'h00, 8'h22, 8'h18, 8'h00,
                              8'hFC, 8'h00, 8'h00, 8'h00, 8'hC6};
    int gaps [11] = '{3, 1, 7, 2, 5, 1, 4, 6, 2, 7, 3};

    prog_loader #(.ADDR_W(8)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .InByte(InByte), .InValid(InValid),
        .InReady(InReady), .MemWre(MemWre), .MemAddr(MemAddr), .MemData(MemData),
        .CpuRST(CpuRST), .Busy(Busy), .Done(Done), .LoadErr(LoadErr)
    );

    always #5 CLK = ~CLK;

    // Record every cycle in which the write strobe is seen high.
    always @(negedge CLK) begin
        if (MemWre === 1'b1) begin
            wr_addr.push_back(MemAddr);
            wr_data.push_back(MemData);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap, input logic st);
        int n;
        repeat (gap) @(negedge CLK);
        InByte = b; InValid = 1'b1; Start = st;
        n = 0;
        while (InReady !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) begin
            vectors++; miscompares++;
            $display("FAIL byte_timeout: InReady=%b required 1", InReady);
        end else begin
            @(negedge CLK);
        end
        InValid = 1'b0; Start = 1'b0;
    endtask

    task automatic pulse_start();
        wr_addr.delete(); wr_data.delete();
        @(negedge CLK);
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic exp_done, input int exp_nwr);
        vectors++;
        if (Done !== exp_done) begin miscompares++; $display("FAIL %s_done: got %b want %b", tag, Done, exp_done); end
        vectors++;
        if (LoadErr !== !exp_done) begin miscompares++; $display("FAIL %s_err: got %b want %b", tag, LoadErr, !exp_done); end
        vectors++;
        if (CpuRST !== !exp_done) begin miscompares++; $display("FAIL %s_cpurst: got %b want %b", tag, CpuRST, !exp_done); end
        vectors++;
        if (Busy !== 1'b0 || InReady !== 1'b0) begin miscompares++; $display("FAIL %s_idle: busy=%b ready=%b want 0 0", tag, Busy, InReady); end
        vectors++;
        if (wr_addr.size() != exp_nwr) begin miscompares++; $display("FAIL %s_nwrites: got %0d want %0d", tag, wr_addr.size(), exp_nwr); end
    endtask

    task automatic check_good_writes(input string tag);
        vectors++;
        if (wr_addr.size() >= 1 && (wr_addr[0] !== 8'h00 || wr_data[0] !== 32'h00221800)) begin
            miscompares++;
            $display("FAIL %s_w0: got %h/%h want 00/00221800", tag, wr_addr[0], wr_data[0]);
        end
        vectors++;
        if (wr_addr.size() >= 2 && (wr_addr[1] !== 8'h04 || wr_data[1] !== 32'hFC000000)) begin
            miscompares++;
            $display("FAIL %s_w1: got %h/%h want 04/fc000000", tag, wr_addr[1], wr_data[1]);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        vectors++;
        if ({InReady, MemWre, MemAddr, MemData, CpuRST, Busy, Done, LoadErr} !== {2'b00, 8'h00, 32'h0, 4'b1000}) begin
            miscompares++;
            $display("FAIL reset_outputs: rdy=%b wre=%b addr=%h data=%h cpurst=%b busy=%b done=%b err=%b",
                     InReady, MemWre, MemAddr, MemData, CpuRST, Busy, Done, LoadErr);
        end
        RST = 1'b0;
    endtask

    task automatic test_good();
        pulse_start();
        vectors++;
        if (InReady !== 1'b1 || CpuRST !== 1'b1 || Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_len_hi: rdy=%b cpurst=%b busy=%b want 1 1 1", InReady, CpuRST, Busy);
        end
        for (int i = 0; i < 11; i++) send_byte(good[i], 0, 1'b0);
        check_result("good", 1'b1, 2);
        check_good_writes("good");
    endtask

    task automatic test_bad_csum();
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(good[i], 0, 1'b0);
        send_byte(8'hC7, 0, 1'b0);
        check_result("badcsum", 1'b0, 2);
        check_good_writes("badcsum");
    endtask

    task automatic test_empty();
        pulse_start();
        send_byte(8'h00, 0, 1'b0); send_byte(8'h00, 0, 1'b0); send_byte(8'h00, 0, 1'b0);
        check_result("empty_ok", 1'b1, 0);
        pulse_start();
        send_byte(8'h00, 0, 1'b0); send_byte(8'h00, 0, 1'b0); send_byte(8'h05, 0, 1'b0);
        check_result("empty_bad", 1'b0, 0);
    endtask

    task automatic test_oversize();
        pulse_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h41, 0, 1'b0);
        check_result("oversize", 1'b0, 0);
        // A 64-word count is the boundary and must be accepted into DATA.
        pulse_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h40, 0, 1'b0);
        vectors++;
        if (Busy !== 1'b1 || InReady !== 1'b1 || LoadErr !== 1'b0) begin
            miscompares++;
            $display("FAIL len64_accept: busy=%b rdy=%b err=%b want 1 1 0", Busy, InReady, LoadErr);
        end
        RST = 1'b1; @(negedge CLK); RST = 1'b0;
    endtask

    task automatic test_gaps_and_start();
        pulse_start();
        // Start is raised alongside payload byte 5 (mid-DATA) and must be ignored.
        for (int i = 0; i < 11; i++) send_byte(good[i], gaps[i], (i == 5));
        check_result("gaps", 1'b1, 2);
        check_good_writes("gaps");
    endtask

    task automatic test_reset_mid_word();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(good[i], 0, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        vectors++;
        if ({InReady, MemWre, MemAddr, MemData, CpuRST, Busy, Done, LoadErr} !== {2'b00, 8'h00, 32'h0, 4'b1000}) begin
            miscompares++;
            $display("FAIL midreset_outputs: rdy=%b wre=%b addr=%h data=%h cpurst=%b busy=%b done=%b err=%b",
                     InReady, MemWre, MemAddr, MemData, CpuRST, Busy, Done, LoadErr);
        end
        vectors++;
        if (wr_addr.size() != 0) begin miscompares++; $display("FAIL midreset_nowrite: got %0d writes want 0", wr_addr.size()); end
        pulse_start();
        for (int i = 0; i < 11; i++) send_byte(good[i], 0, 1'b0);
        check_result("after_reset", 1'b1, 2);
        check_good_writes("after_reset");
    endtask

    initial begin
        test_reset();
        test_good();
        test_bad_csum();
        test_empty();
        test_oversize();
        test_gaps_and_start();
        test_reset_mid_word();
        repeat (2) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
